pushbutton_conditioner: RTL and testbench

PUSHBUTTON_CONDITIONER -- requirements
Module: pushbutton_conditioner

---
 rtl/pushbutton_conditioner.sv | 105 ++++++++++
 tb/tb_pushbutton_conditioner.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pushbutton_conditioner.sv
// ---------------------------------------------------------------------------
// pushbutton_conditioner
//
// Conditions four raw push-button inputs for a processor PUSHBUTTONS port.
// Each button is synchronized through two flops, debounced by requiring
// DEBOUNCE_CYCLES consecutive differing synchronized samples before the
// accepted level changes, and turned into a sticky press-event flag on every
// accepted 0->1 transition. A second press arriving before the processor has
// acknowledged the first raises a sticky overrun flag.
//
// Parameters
//   DEBOUNCE_CYCLES  stable synchronized cycles needed to accept a change (2..255)
//   CNT_W            width of each per-button debounce counter
//
// Ports
//   clk            single clock, rising edge
//   reset          synchronous, active-high reset
//   buttons_raw    [3:0] asynchronous raw levels, 1 = pressed
//   rd_strobe      one-cycle acknowledge; clears press and overrun flags
//   btn_level      [3:0] debounced levels
//   btn_pressed    [3:0] sticky press-event flags
//   btn_overrun    [3:0] sticky "pressed again before acknowledge" flags
//   event_pending  OR of btn_pressed
// ---------------------------------------------------------------------------
module pushbutton_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] buttons_raw,
  input  logic       rd_strobe,
  output logic [3:0] btn_level,
  output logic [3:0] btn_pressed,
  output logic [3:0] btn_overrun,
  output logic       event_pending
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [3:0]       s1_q, s1_d;
  logic [3:0]       s2_q, s2_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       level_q, level_d;
  logic [3:0]       pressed_q, pressed_d;
  logic [3:0]       overrun_q, overrun_d;
  logic [3:0]       rise;

  always_comb begin
    s1_d    = buttons_raw;
    s2_d    = s1_q;
    level_d = level_q;

    // The counter tracks how many consecutive edges the synchronized value
    // has disagreed with the accepted level; any agreement restarts it.
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end

    rise = level_d & ~level_q;

    // A press on the same edge as the acknowledge survives the clear; it is
    // a fresh event, so it cannot count as an overrun.
    if (rd_strobe) begin
      pressed_d = rise;
      overrun_d = '0;
    end else begin
      pressed_d = pressed_q | rise;
      overrun_d = overrun_q | (rise & pressed_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      cnt_q     <= '{default: '0};
      level_q   <= '0;
      pressed_q <= '0;
      overrun_q <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      pressed_q <= pressed_d;
      overrun_q <= overrun_d;
    end
  end

  assign btn_level     = level_q;
  assign btn_pressed   = pressed_q;
  assign btn_overrun   = overrun_q;
  assign event_pending = |pressed_q;

endmodule

// File: tb/tb_pushbutton_conditioner.sv
module tb_pushbutton_conditioner;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] buttons_raw;
  logic       rd_strobe;
  logic [3:0] btn_level;
  logic [3:0] btn_pressed;
  logic [3:0] btn_overrun;
  logic       event_pending;

  int n_total = 0;
  int n_bad   = 0;

  pushbutton_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk           (clk),
    .reset         (reset),
    .buttons_raw   (buttons_raw),
    .rd_strobe     (rd_strobe),
    .btn_level     (btn_level),
    .btn_pressed   (btn_pressed),
    .btn_overrun   (btn_overrun),
    .event_pending (event_pending)
  );

  always #5 clk = ~clk;

  logic [12:0] obs;
  assign obs = {btn_level, btn_pressed, btn_overrun, event_pending};

  // Reference model: a level flips when the last DC synchronized samples
  // (raw samples two edges old and older) all disagree with it.
  logic [3:0] m_hist [$];
  logic [3:0] m_level, m_pressed, m_overrun;

  always @(posedge clk) begin
    logic [3:0] nl, rise, smp;
    bit ad;
    if (reset) begin
      m_hist = {};
      for (int i = 0; i < DC + 2; i++) m_hist.push_back(4'h0);
      m_level   = 4'h0;
      m_pressed = 4'h0;
      m_overrun = 4'h0;
    end else begin
      nl = m_level;
      for (int b = 0; b < 4; b++) begin
        ad = 1'b1;
        for (int j = 1; j <= DC; j++) begin
          smp = m_hist[m_hist.size() - 1 - j];
          if (smp[b] == m_level[b]) ad = 1'b0;
        end
        if (ad) nl[b] = ~m_level[b];
      end
      rise = nl & ~m_level;
      if (rd_strobe) begin
        m_pressed = rise;
        m_overrun = 4'h0;
      end else begin
        m_overrun = m_overrun | (rise & m_pressed);
        m_pressed = m_pressed | rise;
      end
      m_level = nl;
      m_hist.push_back(buttons_raw);
      void'(m_hist.pop_front());
    end
  end

  // One rising edge per call; entered and left at a falling edge.
  task automatic cyc(input logic [3:0] raw, input logic rd, input logic rst);
    buttons_raw = raw;
    rd_strobe   = rd;
    reset       = rst;
    @(negedge clk);
  endtask

  task automatic test_reset();
    cyc(4'hF, 1'b1, 1'b1);
    cyc(4'hF, 1'b1, 1'b1);
    n_total++;
    if (obs !== 13'h0) begin
      n_bad++;
      $display("FAIL reset_state act=%h exp=%h", obs, 13'h0);
    end
  endtask

  task automatic test_clean_press();
    logic [12:0] exp;
    cyc(4'h0, 1'b0, 1'b1);
    cyc(4'h0, 1'b0, 1'b1);
    for (int i = 0; i <= 5; i++) begin
      cyc(4'b0001, 1'b0, 1'b0);
      exp = (i == 5) ? {4'b0001, 4'b0001, 4'b0000, 1'b1} : 13'h0;
      n_total++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL clean_press edge=k+%0d act=%h exp=%h", i, obs, exp);
      end
    end
  endtask

  task automatic test_glitch();
    cyc(4'h0, 1'b0, 1'b1);
    cyc(4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(4'b0100, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      cyc(4'b0000, 1'b0, 1'b0);
      n_total++;
      if (obs !== 13'h0) begin
        n_bad++;
        $display("FAIL glitch_reject cyc=%0d act=%h exp=%h", i, obs, 13'h0);
      end
    end
  endtask

  task automatic test_bounce();
    logic [12:0] exp;
    cyc(4'h0, 1'b0, 1'b1);
    cyc(4'h0, 1'b0, 1'b1);
    cyc(4'b0010, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b0010, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    for (int i = 0; i <= 9; i++) begin
      cyc(4'b0010, 1'b0, 1'b0);
      exp = (i >= 5) ? {4'b0010, 4'b0010, 4'b0000, 1'b1} : 13'h0;
      n_total++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL bounce edge=k+%0d act=%h exp=%h", i, obs, exp);
      end
    end
  endtask

  task automatic test_clear_overrun();
    logic [12:0] exp;
    cyc(4'h0, 1'b0, 1'b1);
    cyc(4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cyc(4'b1000, 1'b0, 1'b0);
    exp = {4'b1000, 4'b1000, 4'b0000, 1'b1};
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL ovr_first_press act=%h exp=%h", obs, exp);
    end
    for (int i = 0; i < 6; i++) cyc(4'b0000, 1'b0, 1'b0);
    exp = {4'b0000, 4'b1000, 4'b0000, 1'b1};
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL ovr_release act=%h exp=%h", obs, exp);
    end
    for (int i = 0; i < 6; i++) cyc(4'b1000, 1'b0, 1'b0);
    exp = {4'b1000, 4'b1000, 4'b1000, 1'b1};
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL ovr_second_press act=%h exp=%h", obs, exp);
    end
    cyc(4'b1000, 1'b1, 1'b0);
    exp = {4'b1000, 4'b0000, 4'b0000, 1'b0};
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL ovr_clear act=%h exp=%h", obs, exp);
    end
    cyc(4'b1000, 1'b0, 1'b0);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL ovr_after_clear act=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_rd_hold();
    logic [12:0] exp;
    cyc(4'h0, 1'b0, 1'b1);
    cyc(4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cyc(4'b0100, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0100, 1'b1, 1'b0);
      exp = {4'b0100, 4'b0000, 4'b0000, 1'b0};
      n_total++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL rd_hold cyc=%0d act=%h exp=%h", i, obs, exp);
      end
    end
  endtask

  task automatic test_race();
    logic [12:0] exp;
    cyc(4'h0, 1'b0, 1'b1);
    cyc(4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cyc(4'b0010, 1'b0, 1'b0);
    for (int i = 0; i <= 5; i++) begin
      cyc(4'b0011, (i == 5), 1'b0);
      exp = (i == 5) ? {4'b0011, 4'b0001, 4'b0000, 1'b1}
                     : {4'b0010, 4'b0010, 4'b0000, 1'b1};
      n_total++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL race edge=k+%0d act=%h exp=%h", i, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] exp;
    cyc(4'h0, 1'b0, 1'b1);
    cyc(4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(4'hF, 1'b0, 1'b0);
    cyc(4'hF, 1'b0, 1'b1);
    n_total++;
    if (obs !== 13'h0) begin
      n_bad++;
      $display("FAIL reset_mid_edge act=%h exp=%h", obs, 13'h0);
    end
    for (int j = 1; j <= 6; j++) begin
      cyc(4'hF, 1'b0, 1'b0);
      exp = (j == 6) ? {4'hF, 4'hF, 4'h0, 1'b1} : 13'h0;
      n_total++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL reset_mid_requal edge=%0d act=%h exp=%h", j, obs, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0]  raw;
    logic [3:0]  mask;
    logic [12:0] exp;
    raw = 4'h0;
    cyc(4'h0, 1'b0, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      mask = 4'h0;
      for (int b = 0; b < 4; b++) mask[b] = ($urandom_range(0, 5) == 0);
      raw = raw ^ mask;
      cyc(raw, ($urandom_range(0, 7) == 0), ($urandom_range(0, 199) == 0));
      exp = {m_level, m_pressed, m_overrun, |m_pressed};
      n_total++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL random cyc=%0d act=%h exp=%h", n, obs, exp);
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    buttons_raw = 4'h0;
    rd_strobe   = 1'b0;
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_clear_overrun();
    test_rd_hold();
    test_race();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
